// File: rtl/csa_pkg.sv
// ----------------------------------------------------------------------------
// csa_pkg
//   Shared constants and helpers for the carry-save resolution logic.
//   CSA_K_DEFAULT / CSA_W_DEFAULT : default operand and chunk widths, also
//                                   used by the carry-save reduction trees.
//   num_chunks(k, w)              : ceil(k / w), the number of W-bit chunks
//                                   (and therefore pipeline stages).
// ----------------------------------------------------------------------------
package csa_pkg;

  localparam int unsigned CSA_K_DEFAULT = 33;
  localparam int unsigned CSA_W_DEFAULT = 11;

  function automatic int unsigned num_chunks(input int unsigned k, input int unsigned w);
    return (k + w - 1) / w;
  endfunction

endpackage

// File: rtl/cpa_chunk.sv
// ----------------------------------------------------------------------------
// cpa_chunk
//   One W-bit slice of the pipelined carry-propagate adder. Registers
//   a + b + carry_in; the carry-out is registered alongside the sum so the
//   next slice consumes it one cycle later together with its own operands.
//   Ports:
//     clk, reset      : clock and synchronous active-high reset
//     en              : pipeline advance; registers hold when low
//     a, b            : W-bit operand chunks
//     carry_in        : carry from the previous slice (0 for slice 0)
//     sum, carry_out  : registered chunk sum and carry-out
// ----------------------------------------------------------------------------
module cpa_chunk #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (W+1)'(carry_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (en) begin
      {carry_out, sum} <= total;
    end
  end

endmodule

// File: rtl/csa_resolve_pipe.sv
// ----------------------------------------------------------------------------
// csa_resolve_pipe
//   Collapses a K-bit carry-save pair (c, s) into the exact (K+1)-bit sum.
//   The carry ripples through L = ceil(K/W) registered W-bit slices, one
//   slice per stage, so the critical path depends on W only.
//   Ports:
//     clk, reset          : clock and synchronous active-high reset
//     in_valid, in_ready  : input handshake (in_ready = !out_valid || out_ready)
//     c_in, s_in          : carry-save pair, K bits each
//     out_valid, out_ready: output handshake
//     sum_out             : c_in + s_in, K+1 bits
//   The whole pipeline advances together or holds together (global stall);
//   empty slots travel as bubbles and are never compacted.
// ----------------------------------------------------------------------------
module csa_resolve_pipe
  import csa_pkg::*;
#(
  parameter int unsigned K = CSA_K_DEFAULT,
  parameter int unsigned W = CSA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] c_in,
  input  logic [K-1:0] s_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K:0]   sum_out
);

  localparam int unsigned L  = num_chunks(K, W);
  localparam int unsigned LW = L * W;

  logic          advance;
  logic          take;
  logic [L-1:0]  valid_reg;
  logic [LW-1:0] c_ext;
  logic [LW-1:0] s_ext;
  logic [W-1:0]  chunk_sum   [L];
  logic          chunk_carry [L];
  logic [LW:0]   sum_full;

  // A narrow top chunk is handled by zero-extending the operands.
  assign c_ext = LW'(c_in);
  assign s_ext = LW'(s_in);

  assign advance   = !valid_reg[L-1] || out_ready;
  assign in_ready  = advance;
  assign take      = in_valid && advance;
  assign out_valid = valid_reg[L-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (advance) begin
      valid_reg <= (valid_reg << 1) | L'(take);
    end
  end

  // Skew registers: position gi holds the not-yet-added chunks gi+1..L-1 of
  // the operand currently in stage gi. Each stage peels off the low chunk.
  genvar gi;
  for (gi = 0; gi < L - 1; gi++) begin : gen_skew
    localparam int unsigned SW = (L - 1 - gi) * W;
    logic [SW-1:0] skew_c_next;
    logic [SW-1:0] skew_s_next;
    logic [SW-1:0] skew_c_reg;
    logic [SW-1:0] skew_s_reg;

    if (gi == 0) begin : gen_first
      assign skew_c_next = c_ext[LW-1:W];
      assign skew_s_next = s_ext[LW-1:W];
    end else begin : gen_rest
      assign skew_c_next = gen_skew[gi-1].skew_c_reg[SW+W-1:W];
      assign skew_s_next = gen_skew[gi-1].skew_s_reg[SW+W-1:W];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        skew_c_reg <= '0;
        skew_s_reg <= '0;
      end else if (advance) begin
        skew_c_reg <= skew_c_next;
        skew_s_reg <= skew_s_next;
      end
    end
  end

  // Adder slices: slice gi adds chunk gi with the carry registered by
  // slice gi-1 for the same operand one cycle earlier.
  for (gi = 0; gi < L; gi++) begin : gen_stage
    logic [W-1:0] a_op;
    logic [W-1:0] b_op;
    logic         carry_in;

    if (gi == 0) begin : gen_first
      assign a_op     = c_ext[W-1:0];
      assign b_op     = s_ext[W-1:0];
      assign carry_in = 1'b0;
    end else begin : gen_rest
      assign a_op     = gen_skew[gi-1].skew_c_reg[W-1:0];
      assign b_op     = gen_skew[gi-1].skew_s_reg[W-1:0];
      assign carry_in = chunk_carry[gi-1];
    end

    cpa_chunk #(
      .W (W)
    ) u_chunk (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .a         (a_op),
      .b         (b_op),
      .carry_in  (carry_in),
      .sum       (chunk_sum[gi]),
      .carry_out (chunk_carry[gi])
    );
  end

  // Deskew registers: position gi carries the finished result chunks
  // 0..gi-1 so they leave together with the top chunk and final carry.
  for (gi = 1; gi < L; gi++) begin : gen_deskew
    localparam int unsigned DW = gi * W;
    logic [DW-1:0] res_lo_next;
    logic [DW-1:0] res_lo_reg;

    if (gi == 1) begin : gen_first
      assign res_lo_next = chunk_sum[0];
    end else begin : gen_rest
      assign res_lo_next = {chunk_sum[gi-1], gen_deskew[gi-1].res_lo_reg};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        res_lo_reg <= '0;
      end else if (advance) begin
        res_lo_reg <= res_lo_next;
      end
    end
  end

  if (L == 1) begin : gen_out_single
    assign sum_full = {chunk_carry[0], chunk_sum[0]};
  end else begin : gen_out_multi
    assign sum_full = {chunk_carry[L-1], chunk_sum[L-1], gen_deskew[L-1].res_lo_reg};
  end

  assign sum_out = sum_full[K:0];

  // Bits above K come only from zero padding and are always 0.
  if (LW > K) begin : gen_drop_hi
    logic unused_hi;
    assign unused_hi = ^sum_full[LW:K+1];
  end

endmodule

// File: doc/csa_resolve_pipe.md
# csa_resolve_pipe

Pipelined carry-propagate adder that collapses a K-bit carry-save pair (c, s) into one (K+1)-bit binary sum. It sits at the output of the carry-save reduction trees in the NTT datapath, just before modular reduction. Carries ripple through W-bit chunks, one chunk per pipeline stage, so timing is independent of K. The pipeline has a valid/ready handshake on both sides and a global stall.

## Interface
Parameters:
- K, 33, operand width of c and s.
- W, 11, chunk width; stage count L = ceil(K/W) (K=33, W=11 gives L=3).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  c_in/s_in hold a valid pair.
- in_ready  output  1  block accepts the pair this cycle.
- c_in  input  K  carry word from the CSA (bit 0 is 0 by CSA contract; not checked).
- s_in  input  K  sum word from the CSA.
- out_valid  output  1  sum_out is valid.
- out_ready  input  1  downstream accepts sum_out.
- sum_out  output  K+1  c_in + s_in, exact, no truncation.

## Operation
- Zero-extend c_in and s_in to L*W bits and split them into chunks 0..L-1, with chunk 0 as the least significant.
- Stage j (0..L-1) registers chunk_j(c) + chunk_j(s) + carry_j, with carry_0 = 0 and carry_{j+1} = the registered carry-out of stage j.
- Chunks not yet consumed travel down skew registers alongside the stage. Finished result chunks travel down deskew registers so that all chunks of one operand leave together.
- sum_out = the low K+1 bits of the concatenation {carry_L, result chunk L-1 .. result chunk 0}. Bits above K are always 0 and are dropped.
- Each stage has a valid bit. The valid bits form a shift register fed by the input handshake (in_valid && in_ready).
- Global stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance = 0, every data and valid register holds.
  - When advance = 1, every register shifts by one stage. A bubble (valid = 0) enters when there is no input handshake.
- Bubbles propagate and are not compacted. Data in bubble slots is don't-care but must not be X after reset.
- There is no FSM; the block is a pure stallable pipeline.

## Timing
- Latency: a pair accepted at edge t drives out_valid = 1 with its sum after edge t+L, provided there is no stall. Each stalled cycle adds one cycle of latency.
- Throughput: one pair per cycle while out_ready = 1.
- Output hold: while out_valid = 1 and out_ready = 0, sum_out and out_valid must stay stable, and in_ready = 0.
- Simultaneous events: when out_valid = 1, out_ready = 1 and in_valid = 1 in the same cycle, the output is consumed and the input is accepted in that cycle.
- Reset:
  - Clears all valid bits and all data, skew, deskew and carry registers to 0.
  - After reset: out_valid = 0, sum_out = 0, in_ready = 1 (combinational from out_valid = 0).
- Reset mid-operation: any in-flight results are discarded. No output is produced for pairs accepted before reset.
- in_ready depends combinationally on out_ready. This is the only combinational input-to-output path; no path from in_valid to in_ready is allowed.

## Structure
- Package csa_pkg:
  - localparam function num_chunks(K, W) = ceil(K/W).
  - Default K and W values, shared with csa_2 instances.
- Sub-module cpa_chunk:
  - W-bit registered adder with a carry_in input and a registered carry_out output.
  - Has an enable input (advance) and the synchronous reset.
  - Instantiated L times in a generate loop.
- The top level holds the skew and deskew registers, the valid shift register, and the advance/in_ready logic.
- The last chunk is narrower when K is not a multiple of W; handle this by zero-extension, not a separate module.

## Test plan
- Carry-propagation test (K=33, W=11): c_in=0x0_0000_0002, s_in=0x0_FFFF_FFFF, out_ready held at 1. Required: out_valid exactly 3 cycles after acceptance, with sum_out=0x1_0000_0001 (carry crosses every chunk).
- Maximum-value test: c_in=0x1_FFFF_FFFE, s_in=0x0_FFFF_FFFF. Required: sum_out=0x2_FFFF_FFFD, with bit K set.
- Back-to-back streaming: 100 random CSA-legal pairs (c_in[0]=0, s_in[K-1]=0), in_valid and out_ready held at 1. Required: 100 consecutive outputs, in order, each matching the reference addition, with no gaps.
- Backpressure test: stream 10 pairs while out_ready toggles randomly with 50% probability. Required: no loss or duplication, sum_out stable while stalled, and in_ready == (!out_valid || out_ready) in every cycle.
- Mid-stream reset: assert reset for 1 cycle with 3 pairs in flight. Required: out_valid=0 and sum_out=0 on the next cycle, none of the 3 pairs ever appear at the output, and a pair accepted after reset returns correctly after 3 cycles.
- Parameter sweep: (K=32, W=8) and (K=33, W=10), with all-zero, all-ones-legal and random pairs. Required: latencies of 4 and 4 cycles respectively, with exact sums.
